// File: rtl/cpu_alu_pkg.sv
// Shared ALU package.
// Holds the subtractor slice width and the state encoding used by the
// multi-precision subtract sequencer.
package cpu_alu_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } sub_seq_state_t;

endpackage

// File: rtl/wide_sub_seq.sv
// wide_sub_seq: multi-precision subtract sequencer.
// Feeds an external 16-bit ripple subtractor one slice per cycle, LSB slice
// first, chaining each slice's borrow-out into the next slice's borrow-in, and
// assembles the W-bit difference, final borrow and zero flag.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request, sampled only in IDLE
//   a, b, bin           minuend, subtrahend, initial borrow (latched on start)
//   busy                high whenever the sequencer is not IDLE
//   done                one-cycle pulse, diff/bo/zero valid
//   diff, bo, zero      result, final borrow-out, diff == 0
//   sub_a, sub_b        slice operands to the subtractor (0 outside RUN)
//   sub_bin             borrow-in to the subtractor (0 outside RUN)
//   sub_diff, sub_bo    combinational return from the subtractor
module wide_sub_seq
  import cpu_alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic               bin,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       diff,
  output logic               bo,
  output logic               zero,
  output logic [SLICE_W-1:0] sub_a,
  output logic [SLICE_W-1:0] sub_b,
  output logic               sub_bin,
  input  logic [SLICE_W-1:0] sub_diff,
  input  logic               sub_bo
);

  localparam int N  = W / SLICE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if (W < SLICE_W || (W % SLICE_W) != 0) begin : g_bad_width
    $error("wide_sub_seq: W must be a non-zero multiple of SLICE_W");
  end

  sub_seq_state_t state;
  logic [IW-1:0]  idx;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           borrow_q;
  logic [W-1:0]   diff_next;

  assign busy = (state != SEQ_IDLE);
  assign done = (state == SEQ_DONE);

  // Slice selection toward the subtractor, and the difference as it will
  // look once the current slice is merged in (used for the zero flag).
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sub_a     = '0;
    sub_b     = '0;
    sub_bin   = 1'b0;
    diff_next = diff;
    if (state == SEQ_RUN) begin
      sub_a   = a_q[idx*SLICE_W +: SLICE_W];
      sub_b   = b_q[idx*SLICE_W +: SLICE_W];
      sub_bin = borrow_q;
      diff_next[idx*SLICE_W +: SLICE_W] = sub_diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are ordinary flops, not a memory array, so
      // they are reset along with the rest of the datapath.
      state    <= SEQ_IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff     <= '0;
      bo       <= 1'b0;
      zero     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx      <= '0;
            state    <= SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          diff     <= diff_next;
          borrow_q <= sub_bo;
          if (idx == LAST_IDX) begin
            // Top slice: final borrow and zero are taken from the merged
            // result so they are valid in the DONE cycle.
            bo    <= sub_bo;
            zero  <= (diff_next == '0);
            state <= SEQ_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SEQ_DONE: state <= SEQ_IDLE;
        default:  state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_sub_seq.sv
// Self-checking bench for wide_sub_seq: a W=64 and a W=16 instance, each
// with a behavioural 16-bit subtractor attached. Expected results come from
// whole-word arithmetic on the operands.
module tb_wide_sub_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=64 instance
  logic        start = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        bin = 1'b0;
  logic        busy, done, bo, zero;
  logic [63:0] diff;
  logic [15:0] sub_a, sub_b, sub_diff;
  logic        sub_bin, sub_bo;

  always_comb {sub_bo, sub_diff} = {1'b0, sub_a} - {1'b0, sub_b} - {16'd0, sub_bin};

  wide_sub_seq #(.W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bo(bo), .zero(zero),
    .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin),
    .sub_diff(sub_diff), .sub_bo(sub_bo)
  );

  // W=16 instance
  logic        s_start = 1'b0;
  logic [15:0] s_a = '0, s_b = '0;
  logic        s_bin = 1'b0;
  logic        s_busy, s_done, s_bo, s_zero;
  logic [15:0] s_diff;
  logic [15:0] s_sub_a, s_sub_b, s_sub_diff;
  logic        s_sub_bin, s_sub_bo;

  always_comb {s_sub_bo, s_sub_diff} = {1'b0, s_sub_a} - {1'b0, s_sub_b} - {16'd0, s_sub_bin};

  wide_sub_seq #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .bin(s_bin),
    .busy(s_busy), .done(s_done), .diff(s_diff), .bo(s_bo), .zero(s_zero),
    .sub_a(s_sub_a), .sub_b(s_sub_b), .sub_bin(s_sub_bin),
    .sub_diff(s_sub_diff), .sub_bo(s_sub_bo)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One W=64 operation, checked cycle by cycle. Called away from a clock edge.
  // With hold=1, start stays high through RUN/DONE carrying a=5, b=3.
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic tbin, input bit hold);
    logic [64:0] full, mask;
    logic        ebor;
    logic [63:0] ediff;
    logic        ebo;
    int          d0;
    full  = {1'b0, ta} - {1'b0, tb_v} - 65'(tbin);
    ediff = full[63:0];
    ebo   = full[64];
    d0    = done_cnt;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      a = 64'd5; b = 64'd3;
    end else begin
      start = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
    end
    for (int k = 0; k < 4; k++) begin
      mask = (65'd1 << (16 * k)) - 65'd1;
      ebor = (k == 0) ? tbin : (({1'b0, ta} & mask) < (({1'b0, tb_v} & mask) + 65'(tbin)));
      check($sformatf("%s busy k%0d", tag, k), 64'(busy), 64'd1);
      check($sformatf("%s done k%0d", tag, k), 64'(done), 64'd0);
      check($sformatf("%s sub_a k%0d", tag, k), 64'(sub_a), 64'(ta[16*k +: 16]));
      check($sformatf("%s sub_b k%0d", tag, k), 64'(sub_b), 64'(tb_v[16*k +: 16]));
      check($sformatf("%s sub_bin k%0d", tag, k), 64'(sub_bin), 64'(ebor));
      @(posedge clk); #1;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy@done"}, 64'(busy), 64'd1);
    check({tag, " diff"}, diff, ediff);
    check({tag, " bo"}, 64'(bo), 64'(ebo));
    check({tag, " zero"}, 64'(zero), 64'(ediff == 64'd0));
    check({tag, " sub_a@done"}, 64'(sub_a), 64'd0);
    @(posedge clk); #1;
    check({tag, " done@idle"}, 64'(done), 64'd0);
    check({tag, " busy@idle"}, 64'(busy), 64'd0);
    check({tag, " diff held"}, diff, ediff);
    check({tag, " bo held"}, 64'(bo), 64'(ebo));
    check({tag, " sub_bin@idle"}, 64'(sub_bin), 64'd0);
    check({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
  endtask

  // One W=16 operation: a single slice, done one cycle after the start edge.
  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tbin);
    logic [16:0] full;
    full = {1'b0, ta} - {1'b0, tb_v} - 17'(tbin);
    s_a = ta; s_b = tb_v; s_bin = tbin; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_a = 16'($urandom); s_b = 16'($urandom);
    check({tag, " busy"}, 64'(s_busy), 64'd1);
    check({tag, " done early"}, 64'(s_done), 64'd0);
    check({tag, " sub_a"}, 64'(s_sub_a), 64'(ta));
    check({tag, " sub_b"}, 64'(s_sub_b), 64'(tb_v));
    check({tag, " sub_bin"}, 64'(s_sub_bin), 64'(tbin));
    @(posedge clk); #1;
    check({tag, " done"}, 64'(s_done), 64'd1);
    check({tag, " diff"}, 64'(s_diff), 64'(full[15:0]));
    check({tag, " bo"}, 64'(s_bo), 64'(full[16]));
    check({tag, " zero"}, 64'(s_zero), 64'(full[15:0] == 16'd0));
    @(posedge clk); #1;
    check({tag, " idle"}, 64'(s_busy | s_done), 64'd0);
  endtask

  initial begin
    int d0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst diff", diff, 64'd0);
    check("rst bo/zero", {62'd0, bo, zero}, 64'd0);
    check("rst sub_a", 64'(sub_a), 64'd0);
    check("rst16 outs", {46'd0, s_diff, s_bo, s_zero}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Borrow out of slice 0 into slice 1
    run_op("t1", 64'h0000_0000_0001_0000, 64'd1, 1'b0, 1'b0);
    // Borrow ripples through every slice
    run_op("t2", 64'd0, 64'd1, 1'b0, 1'b0);
    // Equal operands, without and with borrow-in
    run_op("t3a", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    run_op("t3b", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);

    // start held through RUN/DONE: ignored until the IDLE cycle after DONE
    run_op("t4", 64'h10, 64'h1, 1'b0, 1'b1);
    check("t4 start held in idle", 64'(start), 64'd1);
    run_op("t4 queued", 64'd5, 64'd3, 1'b0, 1'b0);

    // Reset pulsed mid-RUN at idx=2
    a = 64'hAAAA_BBBB_CCCC_DDDD; b = 64'h1111_2222_3333_4444; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5 sub_a idx2", 64'(sub_a), 64'h0000_0000_0000_BBBB);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t5 busy", 64'(busy), 64'd0);
    check("t5 diff", diff, 64'd0);
    check("t5 sub_a", 64'(sub_a), 64'd0);
    check("t5 done", 64'(done), 64'd0);
    check("t5 bo/zero", {62'd0, bo, zero}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("t5 no done", 64'(done_cnt - d0), 64'd0);
    check("t5 idle", 64'(busy), 64'd0);
    run_op("t5 after", 64'd9, 64'd4, 1'b0, 1'b0);

    // Randomized operations, with some equal-operand cases
    for (int i = 0; i < 20; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      if (i % 7 == 3) rb[63:48] = ra[63:48];
      run_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 1'b0);
    end

    // W=16 build
    run16("w16", 16'h0000, 16'h0001, 1'b0);
    run16("w16 eq", 16'h5A5A, 16'h5A5A, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run16($sformatf("w16 rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
